stimulus_table_writer: RTL and testbench

STIMULUS_TABLE_WRITER -- requirements
Module: stimulus_table_writer

---
 rtl/stimulus_table_writer.sv | 185 ++++++++++++++++++
 tb/tb_stimulus_table_writer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stimulus_table_writer.sv
// Two 20-entry stimulus tables holding {val, dot} words with combinational, count-gated reads.
// Define SORTED_INSERT_EN for sorted insertion via SCAN/SHIFT/PLACE; otherwise entries are appended.
module stimulus_table_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_sel,
  input  logic [6:0]  wr_val,
  input  logic [4:0]  wr_dot,
  input  logic        clr,
  input  logic [4:0]  r_Addr1,
  input  logic [4:0]  r_Addr2,
  output logic [11:0] read1,
  output logic [11:0] read2,
  output logic [4:0]  cnt1,
  output logic [4:0]  cnt2,
  output logic        full1,
  output logic        full2,
  output logic        busy,
  output logic        err
);
  localparam int         DEPTH   = 20;
  localparam logic [4:0] MAX_CNT = 5'd20;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, PLACE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic        err_q, err_d;
  logic [11:0] mem1_q [DEPTH];
  logic [11:0] mem2_q [DEPTH];

  // Only one table is written per cycle, so address and data are shared.
  logic        we1, we2;
  logic [4:0]  wa;
  logic [11:0] wd;
  logic        accept, tgt_full, full1_raw, full2_raw;
  logic [11:0] wr_word;

  assign wr_word   = {wr_val, wr_dot};
  assign full1_raw = (cnt1_q == MAX_CNT);
  assign full2_raw = (cnt2_q == MAX_CNT);
  assign tgt_full  = wr_sel ? full2_raw : full1_raw;
  assign accept    = wr_valid && wr_ready;

  assign wr_ready = !rst && (state_q == IDLE);
  assign busy     = !rst && (state_q != IDLE);
  assign full1    = !rst && full1_raw;
  assign full2    = !rst && full2_raw;
  assign cnt1     = cnt1_q;
  assign cnt2     = cnt2_q;
  assign err      = err_q;
  assign read1    = (!rst && (r_Addr1 < cnt1_q)) ? mem1_q[r_Addr1] : 12'h000;
  assign read2    = (!rst && (r_Addr2 < cnt2_q)) ? mem2_q[r_Addr2] : 12'h000;

`ifdef SORTED_INSERT_EN
  logic             sel_q, sel_d;
  logic [11:0]      ent_q, ent_d;
  logic [4:0]       pos_q, pos_d, j_q, j_d;
  logic [4:0]       cur_cnt, scan_pos;
  logic [DEPTH-1:0] gt;
  logic [11:0]      shift_word;

  assign cur_cnt    = sel_q ? cnt2_q : cnt1_q;
  assign shift_word = sel_q ? mem2_q[j_q] : mem1_q[j_q];

  // Strictly-greater compare keeps equal values in arrival order.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign gt[gi] = (5'(gi) < cur_cnt) &&
                      ((sel_q ? mem2_q[gi][11:5] : mem1_q[gi][11:5]) > ent_q[11:5]);
    end
  endgenerate

  always_comb begin
    scan_pos = cur_cnt;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (gt[i]) scan_pos = 5'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    err_d   = 1'b0;
    we1     = 1'b0;
    we2     = 1'b0;
    wa      = '0;
    wd      = '0;
`ifdef SORTED_INSERT_EN
    sel_d = sel_q;
    ent_d = ent_q;
    pos_d = pos_q;
    j_d   = j_q;
`endif
    if (clr) begin
      state_d = IDLE;
      cnt1_d  = '0;
      cnt2_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (tgt_full) begin
              err_d = 1'b1;
            end else begin
`ifdef SORTED_INSERT_EN
              sel_d   = wr_sel;
              ent_d   = wr_word;
              state_d = SCAN;
`else
              wa  = wr_sel ? cnt2_q : cnt1_q;
              wd  = wr_word;
              we1 = !wr_sel;
              we2 = wr_sel;
              if (wr_sel) cnt2_d = cnt2_q + 5'd1;
              else        cnt1_d = cnt1_q + 5'd1;
`endif
            end
          end
        end
`ifdef SORTED_INSERT_EN
        SCAN: begin
          pos_d   = scan_pos;
          j_d     = cur_cnt - 5'd1;
          state_d = (scan_pos == cur_cnt) ? PLACE : SHIFT;
        end
        SHIFT: begin
          wa  = j_q + 5'd1;
          wd  = shift_word;
          we1 = !sel_q;
          we2 = sel_q;
          if (j_q == pos_q) state_d = PLACE;
          else              j_d     = j_q - 5'd1;
        end
        PLACE: begin
          wa  = pos_q;
          wd  = ent_q;
          we1 = !sel_q;
          we2 = sel_q;
          if (sel_q) cnt2_d = cnt2_q + 5'd1;
          else       cnt1_d = cnt1_q + 5'd1;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      err_q   <= 1'b0;
`ifdef SORTED_INSERT_EN
      sel_q <= 1'b0;
      ent_q <= '0;
      pos_q <= '0;
      j_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      err_q   <= err_d;
`ifdef SORTED_INSERT_EN
      sel_q <= sel_d;
      ent_q <= ent_d;
      pos_q <= pos_d;
      j_q   <= j_d;
`endif
    end
  end

  // Stored words survive reset and clear; the counts hide them.
  always_ff @(posedge clk) begin
    if (we1) mem1_q[wa] <= wd;
    if (we2) mem2_q[wa] <= wd;
  end
endmodule

// File: tb/tb_stimulus_table_writer.sv
// Directed bench for stimulus_table_writer; covers append mode by default and
// sorted mode when SORTED_INSERT_EN is defined.
module tb_stimulus_table_writer;
  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ready, wr_sel, clr;
  logic [6:0]  wr_val;
  logic [4:0]  wr_dot, r_Addr1, r_Addr2, cnt1, cnt2;
  logic [11:0] read1, read2;
  logic        full1, full2, busy, err;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  stimulus_table_writer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_val(wr_val), .wr_dot(wr_dot), .clr(clr),
    .r_Addr1(r_Addr1), .r_Addr2(r_Addr2), .read1(read1), .read2(read2),
    .cnt1(cnt1), .cnt2(cnt2), .full1(full1), .full2(full2),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", nvec, tag, obs, exp);
  endtask

  task automatic rd1(input logic [4:0] a, input logic [11:0] exp, input string tag);
    r_Addr1 = a;
    #1;
    chk(tag, read1, exp);
  endtask

  task automatic rd2(input logic [4:0] a, input logic [11:0] exp, input string tag);
    r_Addr2 = a;
    #1;
    chk(tag, read2, exp);
  endtask

`ifdef SORTED_INSERT_EN
  // Accept one entry, then count busy cycles until the block is idle again.
  task automatic ins(input logic s, input logic [6:0] v, input logic [4:0] d, output int n);
    wr_valid = 1'b1; wr_sel = s; wr_val = v; wr_dot = d;
    tick();
    wr_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    if (n >= 50) chk("busy_timeout", 32'd1, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_val = '0; wr_dot = '0;
    clr = 1'b0; r_Addr1 = '0; r_Addr2 = '0;
    tick();
    tick();
    chk("rst_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("cnt1_reset", cnt1, 0);
    chk("cnt2_reset", cnt2, 0);
    chk("err_reset", err, 0);
    chk("ready_idle", wr_ready, 1);
    chk("full1_reset", full1, 0);

`ifndef SORTED_INSERT_EN
    // Back-to-back appends, count steps on the accept edge itself.
    wr_valid = 1'b1; wr_sel = 1'b0;
    wr_val = 7'd5; wr_dot = 5'd1; tick(); chk("cnt1_after1", cnt1, 1);
    wr_val = 7'd3; wr_dot = 5'd2; tick(); chk("cnt1_after2", cnt1, 2);
    wr_val = 7'd9; wr_dot = 5'd3; tick(); chk("cnt1_after3", cnt1, 3);
    wr_valid = 1'b0;
    chk("busy_append", busy, 0);
    rd1(5'd0, 12'h0A1, "read1_0");
    rd1(5'd1, 12'h062, "read1_1");
    rd1(5'd2, 12'h123, "read1_2");
    rd1(5'd3, 12'h000, "read1_3_empty");
    rd1(5'd25, 12'h000, "read1_25_oob");
    chk("full1_at3", full1, 0);

    // Fill the rest of table1 with val = index, dot = 0.
    wr_valid = 1'b1;
    for (int k = 3; k < 20; k++) begin
      wr_val = 7'(k); wr_dot = 5'd0;
      tick();
    end
    wr_valid = 1'b0;
    chk("cnt1_full", cnt1, 20);
    chk("full1_set", full1, 1);
    chk("err_before_drop", err, 0);
    wr_valid = 1'b1; wr_val = 7'd127; wr_dot = 5'd31;
    tick();
    wr_valid = 1'b0;
    chk("err_pulse", err, 1);
    chk("cnt1_after_drop", cnt1, 20);
    tick();
    chk("err_one_cycle", err, 0);
    rd1(5'd19, 12'h260, "read1_19_kept");
    rd1(5'd0, 12'h0A1, "read1_0_kept");

    wr_valid = 1'b1; wr_sel = 1'b1; wr_val = 7'd2; wr_dot = 5'd4;
    tick();
    wr_valid = 1'b0;
    chk("cnt2_ok", cnt2, 1);
    chk("err_tbl2", err, 0);
    rd2(5'd0, 12'h044, "read2_0");

    // Outputs are masked while reset is held.
    rst = 1'b1;
    #1;
    chk("rst_ready_hi", wr_ready, 0);
    chk("rst_full1", full1, 0);
    rd1(5'd0, 12'h000, "rst_read1");
    rd2(5'd0, 12'h000, "rst_read2");
    tick();
    rst = 1'b0;
    #1;
    chk("cnt1_rst2", cnt1, 0);
    chk("cnt2_rst2", cnt2, 0);

    // clr wins over a simultaneous accept.
    wr_valid = 1'b1; wr_sel = 1'b0; wr_val = 7'd6; wr_dot = 5'd5;
    tick();
    chk("cnt1_pre_clr", cnt1, 1);
    rd1(5'd0, 12'h0C5, "read1_pre_clr");
    clr = 1'b1; wr_sel = 1'b1; wr_val = 7'd1;
    tick();
    clr = 1'b0; wr_valid = 1'b0;
    chk("cnt1_clr", cnt1, 0);
    chk("cnt2_clr", cnt2, 0);
    rd1(5'd0, 12'h000, "read1_clr");
    wr_valid = 1'b1; wr_sel = 1'b1; wr_val = 7'd12; wr_dot = 5'd1;
    tick();
    wr_valid = 1'b0;
    chk("cnt2_post_clr", cnt2, 1);
    rd2(5'd0, 12'h181, "read2_post_clr");
`else
    begin
      int n;
      ins(1'b1, 7'd40, 5'd0, n); chk("busy_40", n, 2);
      ins(1'b1, 7'd10, 5'd0, n); chk("busy_10", n, 3);
      ins(1'b1, 7'd25, 5'd0, n); chk("busy_25", n, 3);
      rd2(5'd0, 12'h140, "read2_0");
      rd2(5'd1, 12'h320, "read2_1");
      rd2(5'd2, 12'h500, "read2_2");
      ins(1'b1, 7'd25, 5'd7, n); chk("busy_25b", n, 3);
      chk("cnt2_4", cnt2, 4);
      rd2(5'd1, 12'h320, "read2_1_stable");
      rd2(5'd2, 12'h327, "read2_2_new");
      rd2(5'd3, 12'h500, "read2_3");

      // Entry offered while busy is held until the first idle cycle.
      wr_valid = 1'b1; wr_sel = 1'b0; wr_val = 7'd30; wr_dot = 5'd1;
      tick();
      wr_val = 7'd20; wr_dot = 5'd2;
      chk("ready_busy", wr_ready, 0);
      n = 0;
      while (busy && n < 50) begin n++; tick(); end
      chk("idle_reached", busy, 0);
      tick();
      wr_valid = 1'b0;
      chk("second_accepted", busy, 1);
      n = 0;
      while (busy && n < 50) begin n++; tick(); end
      chk("cnt1_2", cnt1, 2);
      rd1(5'd0, 12'h282, "read1_0_sorted");
      rd1(5'd1, 12'h3C1, "read1_1_sorted");

      // Clear during SHIFT: val 0 must shift all four table2 entries.
      wr_valid = 1'b1; wr_sel = 1'b1; wr_val = 7'd0; wr_dot = 5'd0;
      tick();
      wr_valid = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("cnt1_clr", cnt1, 0);
      chk("cnt2_clr", cnt2, 0);
      chk("busy_clr", busy, 0);
      for (int a = 0; a < 32; a++) begin
        rd1(5'(a), 12'h000, "read1_clr");
        rd2(5'(a), 12'h000, "read2_clr");
      end
      ins(1'b1, 7'd9, 5'd0, n); chk("busy_after_clr", n, 2);
      rd2(5'd0, 12'h120, "read2_after_clr");
      chk("cnt2_after_clr", cnt2, 1);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
